instr_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 8-bit datapath.
- Fetches 16-bit instructions over a req/ack port and decodes them.
- Drives the register file's read selects (SA, SB), write select (DR), write strobe (LD) and write data (D_OUT), plus the ALU opcode.
- Consumes the register file's DATA_A and the external combinational ALU result; directly upstream of the register file.

---
 rtl/instr_sequencer.sv | 82 ++++++++
 tb/tb_instr_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/writeback control sequencer
// driving register-file selects, write strobe/data and the ALU opcode.
module instr_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            RUN,
   output logic            IMEM_REQ,
   output logic [PC_W-1:0] IMEM_ADDR,
   input  logic            IMEM_ACK,
   input  logic [15:0]     INSTR,
   input  logic [7:0]      DATA_A,
   input  logic [7:0]      ALU_RESULT,
   output logic [2:0]      SA,
   output logic [2:0]      SB,
   output logic [2:0]      DR,
   output logic            LD,
   output logic [7:0]      D_OUT,
   output logic [2:0]      ALU_OP,
   output logic            HALTED,
   output logic            ILLEGAL
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

   state_t          r_state, w_next;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic [7:0]      r_res;
   logic [3:0]      w_op;
   logic            w_alu, w_wr, w_jump;

   assign w_op   = r_ir[15:12];
   assign w_alu  = (w_op >= 4'd1) && (w_op <= 4'd5);
   assign w_wr   = w_alu || (w_op == 4'd6) || (w_op == 4'd7);
   assign w_jump = (w_op == 4'd9) || ((w_op == 4'd8) && (DATA_A == 8'h00));

   assign DR        = r_ir[11:9];
   assign SA        = r_ir[8:6];
   assign SB        = r_ir[5:3];
   assign ALU_OP    = w_alu ? 3'(w_op - 4'd1) : 3'd0;
   assign IMEM_REQ  = (r_state == S_FETCH);
   assign IMEM_ADDR = r_pc;
   assign LD        = (r_state == S_WB);
   assign D_OUT     = r_res;
   assign HALTED    = (r_state == S_HALT);
   assign ILLEGAL   = (r_state == S_EXEC) && (w_op >= 4'd10) && (w_op <= 4'd14);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = RUN ? S_FETCH : S_IDLE;
         S_FETCH:  w_next = IMEM_ACK ? S_DECODE : S_FETCH;
         S_DECODE: w_next = S_EXEC;
         S_EXEC:   w_next = w_wr ? S_WB : (w_op == 4'd15) ? S_HALT : RUN ? S_FETCH : S_IDLE;
         S_WB:     w_next = RUN ? S_FETCH : S_IDLE;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_ir    <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && IMEM_ACK) begin
            r_ir <= INSTR;
            r_pc <= r_pc + PC_W'(1);
         end
         // taken branch target replaces the PC already advanced in FETCH
         if (r_state == S_EXEC) begin
            if (w_wr) r_res <= w_alu ? ALU_RESULT : (w_op == 4'd6) ? r_ir[7:0] : DATA_A;
            if (w_jump) r_pc <= PC_W'(r_ir[7:0]);
         end
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven directed checks of instr_sequencer plus
// hand-written sequences for ack wait, HALT, reset mid-instruction and RUN drop.
module tb_instr_sequencer;
   logic       CLK = 1'b0, RESET = 1'b0, RUN = 1'b0, IMEM_ACK = 1'b0;
   logic [15:0] INSTR = '0;
   logic [7:0] DATA_A = '0, ALU_RESULT = '0;
   logic       IMEM_REQ, LD, HALTED, ILLEGAL;
   logic [7:0] IMEM_ADDR, D_OUT;
   logic [2:0] SA, SB, DR, ALU_OP;

   instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .CLK(CLK), .RESET(RESET), .RUN(RUN), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
      .IMEM_ACK(IMEM_ACK), .INSTR(INSTR), .DATA_A(DATA_A), .ALU_RESULT(ALU_RESULT),
      .SA(SA), .SB(SB), .DR(DR), .LD(LD), .D_OUT(D_OUT), .ALU_OP(ALU_OP),
      .HALTED(HALTED), .ILLEGAL(ILLEGAL)
   );

   always #5 CLK = ~CLK;

   int cnt = 0, base = 0, ncmp = 0, nerr = 0, vi = 0;
   always @(posedge CLK) cnt <= cnt + 1;

   typedef struct {
      logic [15:0] ins;
      int          dly;
      logic [7:0]  da, ar, addr;
      logic        ld;
      logic [2:0]  dr;
      logic [7:0]  dout;
      logic [2:0]  aop, sa, sb;
      int          ill;
      logic [7:0]  nxt;
      int          cyc, ldpos, ldabs;
   } vec_t;

   vec_t v[16];

   function automatic vec_t mk(input logic [7:0] addr, input logic [15:0] ins, input int dly,
                               input logic [7:0] da, ar, input logic ld, input logic [2:0] dr,
                               input logic [7:0] dout, input logic [2:0] aop, sa, sb,
                               input int ill, input logic [7:0] nxt, input int cyc, ldpos, ldabs);
      vec_t t;
      t.addr = addr; t.ins = ins; t.dly = dly; t.da = da; t.ar = ar; t.ld = ld; t.dr = dr;
      t.dout = dout; t.aop = aop; t.sa = sa; t.sb = sb; t.ill = ill; t.nxt = nxt;
      t.cyc = cyc; t.ldpos = ldpos; t.ldabs = ldabs;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      ncmp++;
      if (a !== e) begin
         nerr++;
         $display("FAIL v%0d %s: got %0h expected %0h", vi, nm, a, e);
      end
   endtask

   task automatic run_vec(input vec_t t);
      int k, n, ill, ldn, ldpos, ldabs;
      logic [7:0] a0, dout;
      logic [2:0] dr, sa, sb, aop;
      k = 0; n = 0; ill = 0; ldn = 0; ldpos = 0; ldabs = 0;
      dout = '0; dr = '0; sa = '0; sb = '0; aop = '0;
      DATA_A = t.da; ALU_RESULT = t.ar;
      while (!IMEM_REQ && k < 10) begin @(negedge CLK); k++; end
      chk("req", 32'(IMEM_REQ), 32'd1);
      a0 = IMEM_ADDR;
      chk("addr", 32'(a0), 32'(t.addr));
      IMEM_ACK = 1'b0;
      repeat (t.dly) begin
         @(negedge CLK); n++;
         chk("hold", {23'd0, IMEM_REQ, IMEM_ADDR}, {23'd0, 1'b1, a0});
      end
      IMEM_ACK = 1'b1; INSTR = t.ins;
      do begin
         @(negedge CLK); IMEM_ACK = 1'b0; n++;
         if (n == t.dly + 1) begin sa = SA; sb = SB; aop = ALU_OP; end
         if (LD) begin ldn++; ldpos = n; dr = DR; dout = D_OUT; ldabs = cnt - base; end
         if (ILLEGAL) ill++;
      end while (!IMEM_REQ && n < t.dly + 10);
      chk("cycles", 32'(n), 32'(t.cyc));
      chk("ld_count", 32'(ldn), 32'(t.ld));
      if (t.ld) begin
         chk("dr", 32'(dr), 32'(t.dr));
         chk("d_out", 32'(dout), 32'(t.dout));
         chk("ld_pos", 32'(ldpos), 32'(t.ldpos));
      end
      if (t.ldabs != 0) chk("ld_abs", 32'(ldabs), 32'(t.ldabs));
      chk("alu_op", 32'(aop), 32'(t.aop));
      chk("sa", 32'(sa), 32'(t.sa));
      chk("sb", 32'(sb), 32'(t.sb));
      chk("illegal", 32'(ill), 32'(t.ill));
      chk("next_addr", 32'(IMEM_ADDR), 32'(t.nxt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      //        addr   ins      dly da     ar     ld dr dout   aop sa sb ill nxt    cyc ldp abs
      v[0]  = mk(8'h00, 16'h6205, 0, 8'h00, 8'h00, 1, 1, 8'h05, 0, 0, 0, 0, 8'h01, 4, 3, 4);
      v[1]  = mk(8'h01, 16'h6403, 0, 8'h00, 8'h00, 1, 2, 8'h03, 0, 0, 0, 0, 8'h02, 4, 3, 8);
      v[2]  = mk(8'h02, 16'h1650, 0, 8'h05, 8'h08, 1, 3, 8'h08, 0, 1, 2, 0, 8'h03, 4, 3, 12);
      v[3]  = mk(8'h03, 16'h625A, 3, 8'h00, 8'h00, 1, 1, 8'h5A, 0, 1, 3, 0, 8'h04, 7, 6, 0);
      v[4]  = mk(8'h04, 16'h2850, 0, 8'h05, 8'h02, 1, 4, 8'h02, 1, 1, 2, 0, 8'h05, 4, 3, 0);
      v[5]  = mk(8'h05, 16'h5A50, 0, 8'h00, 8'h06, 1, 5, 8'h06, 4, 1, 2, 0, 8'h06, 4, 3, 0);
      v[6]  = mk(8'h06, 16'h7C40, 0, 8'h05, 8'hFF, 1, 6, 8'h05, 0, 1, 0, 0, 8'h07, 4, 3, 0);
      v[7]  = mk(8'h07, 16'h8040, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h40, 3, 0, 0);
      v[8]  = mk(8'h40, 16'h8040, 0, 8'h01, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h41, 3, 0, 0);
      v[9]  = mk(8'h41, 16'h9080, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 2, 0, 0, 8'h80, 3, 0, 0);
      v[10] = mk(8'h80, 16'h0000, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h81, 3, 0, 0);
      v[11] = mk(8'h81, 16'hC000, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 8'h82, 3, 0, 0);
      v[12] = mk(8'h82, 16'h3E50, 0, 8'h00, 8'h01, 1, 7, 8'h01, 2, 1, 2, 0, 8'h83, 4, 3, 0);
      v[13] = mk(8'h83, 16'h4050, 0, 8'h00, 8'h07, 1, 0, 8'h07, 3, 1, 2, 0, 8'h84, 4, 3, 0);
      v[14] = mk(8'h84, 16'h90FF, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 3, 7, 0, 8'hFF, 3, 0, 0);
      v[15] = mk(8'hFF, 16'h0000, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3, 0, 0);

      repeat (3) @(negedge CLK);
      chk("rst_ctrl", {28'd0, IMEM_REQ, LD, HALTED, ILLEGAL}, 32'd0);
      chk("rst_addr", 32'(IMEM_ADDR), 32'd0);
      chk("rst_dout", 32'(D_OUT), 32'd0);
      chk("rst_sel", {20'd0, ALU_OP, DR, SA, SB}, 32'd0);

      RUN = 1'b1; RESET = 1'b1; base = cnt;
      for (int i = 0; i < 16; i++) begin vi = i; run_vec(v[i]); end

      vi = 100;
      IMEM_ACK = 1'b1; INSTR = 16'hF000;
      k = 0;
      do begin @(negedge CLK); IMEM_ACK = 1'b0; k++; end while (!HALTED && k < 6);
      chk("halt_lat", 32'(k), 32'd3);
      for (int i = 0; i < 20; i++) begin
         RUN = i[0];
         @(negedge CLK);
         chk("halt_quiet", {29'd0, IMEM_REQ, LD, HALTED}, 32'd1);
      end
      RESET = 1'b0; #1;
      chk("halt_rst", {28'd0, HALTED, IMEM_REQ, LD, ILLEGAL}, 32'd0);
      chk("halt_rst_pc", 32'(IMEM_ADDR), 32'd0);

      vi = 101;
      @(negedge CLK); RUN = 1'b1; RESET = 1'b1;
      @(negedge CLK);
      chk("re_fetch", {23'd0, IMEM_REQ, IMEM_ADDR}, {23'd0, 1'b1, 8'h00});
      IMEM_ACK = 1'b1; INSTR = 16'h1650; ALU_RESULT = 8'h33;
      @(negedge CLK); IMEM_ACK = 1'b0;
      @(negedge CLK);
      chk("exec_sel", {26'd0, DR, ALU_OP}, {26'd0, 3'd3, 3'd0});
      RESET = 1'b0; #1;
      chk("async_ctrl", {28'd0, IMEM_REQ, LD, HALTED, ILLEGAL}, 32'd0);
      chk("async_sel", {20'd0, ALU_OP, DR, SA, SB}, 32'd0);
      chk("async_dout", 32'(D_OUT), 32'd0);
      chk("async_pc", 32'(IMEM_ADDR), 32'd0);
      k = 0;
      repeat (3) begin @(negedge CLK); if (LD) k++; end
      chk("no_ld_in_rst", 32'(k), 32'd0);

      vi = 102;
      RESET = 1'b1;
      k = 0;
      do begin @(negedge CLK); k++; end while (!IMEM_REQ && k < 6);
      chk("run_fetch", 32'(IMEM_ADDR), 32'd0);
      IMEM_ACK = 1'b1; INSTR = 16'h6277;
      k = 0;
      do begin @(negedge CLK); IMEM_ACK = 1'b0; k++; end while (!LD && k < 8);
      chk("run_ld_pos", 32'(k), 32'd3);
      chk("run_ld", {21'd0, LD, DR, D_OUT}, {21'd0, 1'b1, 3'd1, 8'h77});
      RUN = 1'b0;
      k = 0;
      repeat (10) begin @(negedge CLK); if (IMEM_REQ || LD) k++; end
      chk("idle_quiet", 32'(k), 32'd0);
      chk("idle_dout", 32'(D_OUT), 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
